// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
//
// Forwarding and load-use hazard unit for the pipelined LEGv8 datapath.
// A short registered "tag pipeline" remembers the destination register of
// every instruction that has left EX during the last DEPTH cycles. Tag
// stage 0 is EX/MEM, stage 1 is MEM/WB, and so on. Each source operand of
// the instruction currently in EX is compared against those tags:
//   - a hit selects the youngest producing stage as a bypass source;
//   - a hit on a load whose data is not yet available raises a stall.
//
// Parameters
//   NSRC        number of source operands of the EX instruction
//   DEPTH       number of forwardable tag stages after EX
//   REGW        register index width
//   ZREG        zero register index (never tracked, never forwarded)
//   LOAD_STAGE  first tag stage whose load data can be forwarded
//   SELW        width of one forward select (derived from DEPTH)
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset
//   ex_valid   a valid instruction sits in EX this cycle
//   ex_rd      destination register of the EX instruction
//   ex_wb      the EX instruction writes the register file
//   ex_load    the EX instruction is a load
//   src_reg    source indices, operand i at [i*REGW +: REGW]
//   src_used   operand i is actually read
//   hold       external freeze of the whole pipeline
//   flush      squash the EX instruction this cycle
//   fwd_sel    per operand, 0 = register file, k = tag stage k-1
//   stall      load-use hazard, EX must not advance
//   stall_cnt  saturating count of stall cycles (FWD_STALL_CNT_EN only)
//
// Optional feature macro: FWD_STALL_CNT_EN
//   When defined, a 16-bit saturating stall cycle counter and its output
//   port stall_cnt are added. When undefined neither exists.
// ---------------------------------------------------------------------------
module fwd_scoreboard #(
    parameter int NSRC       = 2,
    parameter int DEPTH      = 2,
    parameter int REGW       = 5,
    parameter int ZREG       = 31,
    parameter int LOAD_STAGE = 1,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ex_valid,
    input  logic [REGW-1:0]        ex_rd,
    input  logic                   ex_wb,
    input  logic                   ex_load,
    input  logic [NSRC*REGW-1:0]   src_reg,
    input  logic [NSRC-1:0]        src_used,
    input  logic                   hold,
    input  logic                   flush,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   stall
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);

    localparam logic [REGW-1:0] ZIDX = REGW'(ZREG);

    // Tag pipeline state, one entry per stage past EX.
    logic [DEPTH-1:0]           tag_v_q,  tag_v_d;
    logic [DEPTH-1:0][REGW-1:0] tag_rd_q, tag_rd_d;
    logic [DEPTH-1:0]           tag_ld_q, tag_ld_d;

    logic [NSRC*SELW-1:0] sel_raw;
    logic                 hazard_any;
    logic                 new_v;

    // Operand lookup. Stages are scanned from youngest to oldest and the
    // first hit is latched, so an older copy of the same register can never
    // override newer data. Only the youngest hit decides the hazard: an
    // older load of a register that has since been rewritten is harmless.
    always_comb begin
        logic [REGW-1:0] src;
        logic            found;
        sel_raw    = '0;
        hazard_any = 1'b0;
        src        = '0;
        found      = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src   = src_reg[i*REGW +: REGW];
            found = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && tag_v_q[k] && (tag_rd_q[k] == src) &&
                    src_used[i] && (src != ZIDX)) begin
                    found                     = 1'b1;
                    sel_raw[i*SELW +: SELW]   = SELW'(k + 1);
                    if (tag_ld_q[k] && (k < LOAD_STAGE)) begin
                        hazard_any = 1'b1;
                    end
                end
            end
        end
    end

    // A flushed instruction cannot stall anything. While stalling, every
    // select is forced to the register file so the stalled operand values
    // are never mistaken for valid bypass data.
    always_comb begin
        stall   = ex_valid & ~flush & hazard_any;
        fwd_sel = stall ? '0 : sel_raw;
    end

    // Next tag state. A stalled EX instruction enters stage 0 as a bubble
    // while older entries keep draining, which is what lets the load move
    // into a forwardable stage. Under hold nothing moves at all.
    always_comb begin
        new_v    = ex_valid & ex_wb & (ex_rd != ZIDX) & ~flush & ~stall;
        tag_v_d  = tag_v_q;
        tag_rd_d = tag_rd_q;
        tag_ld_d = tag_ld_q;
        if (!hold) begin
            tag_v_d[0]  = new_v;
            tag_rd_d[0] = ex_rd;
            tag_ld_d[0] = ex_load;
            for (int k = 1; k < DEPTH; k++) begin
                tag_v_d[k]  = tag_v_q[k-1];
                tag_rd_d[k] = tag_rd_q[k-1];
                tag_ld_d[k] = tag_ld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_q  <= '0;
            tag_rd_q <= '0;
            tag_ld_q <= '0;
        end else begin
            tag_v_q  <= tag_v_d;
            tag_rd_q <= tag_rd_d;
            tag_ld_q <= tag_ld_d;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Only cycles that actually cost progress are counted: a stall under
    // hold is not charged because the pipeline was frozen anyway.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !hold && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_fwd_scoreboard
//
// Directed bench for fwd_scoreboard with default parameters
// (NSRC=2, DEPTH=2, REGW=5, ZREG=31, LOAD_STAGE=1, SELW=2).
// fwd_sel layout: operand 0 in bits [1:0], operand 1 in bits [3:2].
// ---------------------------------------------------------------------------
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_wb;
    logic        ex_load;
    logic [9:0]  src_reg;
    logic [1:0]  src_used;
    logic        hold;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    fwd_scoreboard dut (
        .clk      (clk),
        .reset    (reset),
        .ex_valid (ex_valid),
        .ex_rd    (ex_rd),
        .ex_wb    (ex_wb),
        .ex_load  (ex_load),
        .src_reg  (src_reg),
        .src_used (src_used),
        .hold     (hold),
        .flush    (flush),
        .fwd_sel  (fwd_sel),
        .stall    (stall)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock, then settle 2 time units past the edge so outputs
    // are sampled well away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_ex(input logic v, input logic [4:0] rd,
                            input logic wb, input logic ld);
        ex_valid = v;
        ex_rd    = rd;
        ex_wb    = wb;
        ex_load  = ld;
    endtask

    task automatic drive_src(input logic [4:0] s0, input logic [4:0] s1,
                             input logic [1:0] used);
        src_reg  = {s1, s0};
        src_used = used;
    endtask

    task automatic go_idle();
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0);
        drive_src(5'd0, 5'd0, 2'b00);
        hold  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        go_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        drive_src(5'd0, 5'd0, 2'b11);
        drive_ex(1'b1, 5'd1, 1'b0, 1'b0);
        #1;
        checks++;
        if (fwd_sel !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_sel got=%b exp=%b", fwd_sel, 4'b0000);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stall got=%b exp=%b", stall, 1'b0);
        end
`ifdef FWD_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_cnt got=%0d exp=%0d", stall_cnt, 0);
        end
`endif
        go_idle();
    endtask

    task automatic test_forward();
        do_reset();
        drive_ex(1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        drive_ex(1'b1, 5'd0, 1'b0, 1'b0);
        drive_src(5'd3, 5'd0, 2'b01);
        #1;
        checks++;
        if (fwd_sel !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL fwd_stage0 got=%b exp=%b", fwd_sel, 4'b0001);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL fwd_stage1 got=%b exp=%b", fwd_sel, 4'b0010);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL fwd_aged_out got=%b exp=%b", fwd_sel, 4'b0000);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_ex(1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        tick();
        drive_ex(1'b1, 5'd0, 1'b0, 1'b0);
        drive_src(5'd5, 5'd5, 2'b11);
        #1;
        checks++;
        if (fwd_sel !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL b2b_youngest got=%b exp=%b", fwd_sel, 4'b0101);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_stall got=%b exp=%b", stall, 1'b0);
        end
        // Distinct producers in different stages feed different operands.
        go_idle();
        tick();
        tick();
        drive_ex(1'b1, 5'd6, 1'b1, 1'b0);
        tick();
        drive_ex(1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        drive_ex(1'b1, 5'd0, 1'b0, 1'b0);
        drive_src(5'd6, 5'd9, 2'b11);
        #1;
        checks++;
        if (fwd_sel !== 4'b0110) begin
            failures++;
            $display("[TB] FAIL mixed_stages got=%b exp=%b", fwd_sel, 4'b0110);
        end
        go_idle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive_ex(1'b1, 5'd7, 1'b1, 1'b1);
        tick();
        // Reader of X7 that itself writes X8.
        drive_ex(1'b1, 5'd8, 1'b1, 1'b0);
        drive_src(5'd7, 5'd8, 2'b11);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lu_stall got=%b exp=%b", stall, 1'b1);
        end
        checks++;
        if (fwd_sel !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL lu_sel_during got=%b exp=%b", fwd_sel, 4'b0000);
        end
        tick();
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lu_release got=%b exp=%b", stall, 1'b0);
        end
        // Operand 1 (X8) must see a bubble in stage 0, not the stalled writer.
        checks++;
        if (fwd_sel !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL lu_sel_after got=%b exp=%b", fwd_sel, 4'b0010);
        end
`ifdef FWD_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL lu_cnt got=%0d exp=%0d", stall_cnt, 1);
        end
`endif
        tick();
        drive_ex(1'b1, 5'd0, 1'b0, 1'b0);
        drive_src(5'd8, 5'd0, 2'b01);
        #1;
        checks++;
        if (fwd_sel !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL lu_writer_tracked got=%b exp=%b", fwd_sel, 4'b0001);
        end
        go_idle();
    endtask

    task automatic test_zero_and_unused();
        do_reset();
        drive_ex(1'b1, 5'd31, 1'b1, 1'b1);
        tick();
        drive_ex(1'b1, 5'd0, 1'b0, 1'b0);
        drive_src(5'd31, 5'd31, 2'b11);
        #1;
        checks++;
        if ({stall, fwd_sel} !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL zero_reg got=%b exp=%b", {stall, fwd_sel}, 5'b00000);
        end
        go_idle();
        tick();
        drive_ex(1'b1, 5'd4, 1'b0, 1'b0);
        tick();
        drive_ex(1'b1, 5'd0, 1'b0, 1'b0);
        drive_src(5'd4, 5'd0, 2'b01);
        #1;
        checks++;
        if ({stall, fwd_sel} !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL no_wb got=%b exp=%b", {stall, fwd_sel}, 5'b00000);
        end
        go_idle();
        tick();
        drive_ex(1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        drive_ex(1'b1, 5'd0, 1'b0, 1'b0);
        drive_src(5'd10, 5'd10, 2'b10);
        #1;
        checks++;
        if (fwd_sel !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL src_unused got=%b exp=%b", fwd_sel, 4'b0100);
        end
        go_idle();
    endtask

    task automatic test_hold();
        do_reset();
        drive_ex(1'b1, 5'd7, 1'b1, 1'b1);
        tick();
        drive_ex(1'b1, 5'd0, 1'b0, 1'b0);
        drive_src(5'd7, 5'd0, 2'b01);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_stall_c0 got=%b exp=%b", stall, 1'b1);
        end
        hold = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) hold = 1'b0;
            #1;
            checks++;
            if (stall !== 1'b1) begin
                failures++;
                $display("[TB] FAIL hold_stall_c%0d got=%b exp=%b", c, stall, 1'b1);
            end
        end
        tick();
        checks++;
        if ({stall, fwd_sel} !== 5'b00010) begin
            failures++;
            $display("[TB] FAIL hold_release got=%b exp=%b", {stall, fwd_sel}, 5'b00010);
        end
`ifdef FWD_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL hold_cnt got=%0d exp=%0d", stall_cnt, 1);
        end
`endif
        go_idle();
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        drive_ex(1'b1, 5'd2, 1'b1, 1'b1);
        tick();
        drive_ex(1'b1, 5'd12, 1'b1, 1'b0);
        drive_src(5'd2, 5'd0, 2'b01);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_stall got=%b exp=%b", stall, 1'b0);
        end
        tick();
        flush = 1'b0;
        drive_ex(1'b1, 5'd0, 1'b0, 1'b0);
        drive_src(5'd12, 5'd2, 2'b11);
        #1;
        checks++;
        if ({stall, fwd_sel} !== 5'b01000) begin
            failures++;
            $display("[TB] FAIL flush_untracked got=%b exp=%b", {stall, fwd_sel}, 5'b01000);
        end
        go_idle();
        tick();
        tick();
        drive_ex(1'b1, 5'd7, 1'b1, 1'b1);
        tick();
        drive_ex(1'b1, 5'd0, 1'b0, 1'b0);
        drive_src(5'd7, 5'd7, 2'b11);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_stall_pre got=%b exp=%b", stall, 1'b1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({stall, fwd_sel} !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL mid_stall_reset got=%b exp=%b", {stall, fwd_sel}, 5'b00000);
        end
`ifdef FWD_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL mid_stall_cnt got=%0d exp=%0d", stall_cnt, 0);
        end
`endif
        go_idle();
    endtask

    initial begin
        reset = 1'b1;
        go_idle();
        test_reset();
        test_forward();
        test_back_to_back();
        test_load_use();
        test_zero_and_unused();
        test_hold();
        test_flush_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
Parametrised forwarding and hazard unit for the pipelined LEGv8 datapath. It keeps a registered tag pipeline of destination registers for the DEPTH stages past EX. It produces one forward-select per source operand of the instruction in EX, and a load-use stall. It generalises the two-stage, two-operand forwarding logic to N operands, N stages and a configurable load latency, with a hold/flush interface.

Parameters:
NSRC, 2, number of source operands of the EX instruction
DEPTH, 2, number of forwardable stages after EX (stage 0 = EX/MEM, stage 1 = MEM/WB, ...)
REGW, 5, register index width
ZREG, 31, zero register index; never forwarded, never tracked
LOAD_STAGE, 1, first tag stage index from which load data is forwardable (1..DEPTH-1)
SELW, $clog2(DEPTH+1), derived; width of each forward select

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ex_valid  in  1  valid instruction in EX this cycle
ex_rd  in  REGW  destination of EX instruction
ex_wb  in  1  EX instruction writes the register file
ex_load  in  1  EX instruction is a load
src_reg  in  NSRC*REGW  source register indices, operand i at [i*REGW +: REGW]
src_used  in  NSRC  operand i is actually read
hold  in  1  whole pipeline frozen this cycle (external stall)
flush  in  1  squash EX instruction this cycle
fwd_sel  out  NSRC*SELW  per operand: 0 = register file, k = forward from tag stage k-1
stall  out  1  load-use hazard; EX must not advance
stall_cnt  out  16  stall cycle counter (present only with FWD_STALL_CNT_EN)

Behaviour:
- Tag entry T[k], k = 0..DEPTH-1: {v, rd, ld}, all registered.
- Reset: all T[k].v = 0; stall = 0; fwd_sel = 0; stall_cnt = 0.
- New entry N = {ex_valid & ex_wb & (ex_rd != ZREG) & ~flush & ~stall, ex_rd, ex_load}.
- Update priority per posedge:
  - reset: clear all entries.
  - else if hold: all T hold.
  - else: T[0] <= N; T[k] <= T[k-1] for k >= 1. The oldest entry drops out.
  - When stall = 1 and hold = 0, N is a bubble (v = 0) and older stages still advance.
- Match for operand i: m(k) = T[k].v & (T[k].rd == src_i) & src_used[i] & (src_i != ZREG).
- Youngest (smallest k) match wins. Older matches are ignored.
- Hazard for operand i: its youngest match has T[k].ld = 1 and k < LOAD_STAGE.
- stall = ex_valid & ~flush & (any operand hazard). Combinational, same cycle.
- fwd_sel[i]:
  - 0 if stall = 1, or if there is no match.
  - otherwise k+1 for the youngest match k.
  - Fully combinational from registered tags and current inputs; zero latency.
- Stall duration: LOAD_STAGE - k cycles for a load found at stage k. Hold cycles extend this, since tags do not move.
- Simultaneous events:
  - flush overrides stall.
  - hold with stall keeps stall asserted and tags frozen.
  - reset overrides everything.
- Reset mid-stall: stall drops in the cycle after reset, because all tags are invalid.
- A non-load match at k < LOAD_STAGE forwards normally.
- The same rd in several stages resolves to the youngest one.

Optional Feature:
FWD_STALL_CNT_EN
- Defined: stall_cnt increments by 1 on every posedge where stall = 1, hold = 0 and reset = 0. It saturates at 16'hFFFF and is cleared by reset.
- Undefined: the stall_cnt port and its counter do not exist; no other behaviour changes.

Test Plan:
- Reset, then ex_valid=1, ex_rd=3, ex_wb=1 for one cycle; next cycle src0=3 -> fwd_sel0=1. Following cycle -> fwd_sel0=2. Cycle after that -> 0.
- Back-to-back writes to X5 (two instructions); third instruction reads src0=5, src1=5 -> both selects = 1, the youngest.
- Load to X7 followed immediately by a reader of X7 (LOAD_STAGE=1) -> stall=1 for exactly 1 cycle with fwd_sel0=0. Next cycle: stall=0, fwd_sel0=2, and T[0].v=0 (bubble).
- Writes to X31, or ex_wb=0, followed by a reader of 31 -> fwd_sel=0, stall=0. Also src_used=0 with a matching reg -> 0.
- Load-use stall with hold=1 for 3 cycles -> stall held high 4 cycles total. With FWD_STALL_CNT_EN, stall_cnt=1 after release.
- Load to X2 in T[0] and flush=1 on the dependent instruction -> stall=0. The flushed instruction's rd is not tracked. Assert reset mid-stall -> stall=0 the next cycle and all selects 0.
